chain_score_pipe: RTL and testbench

Pipelined, parametrised successor to the single-pair computeScore unit for the minimap2 chaining DSA. It accepts one anchor pair (i, j) per cycle under a valid/ready handshake and emits a signed chaining score: alpha minus gap cost, or NEG_INF for illegal pairs. Pairs are tagged and grouped: the last pair of a group for anchor i is marked with in_last, and the block also reports the best-scoring predecessor of each group. It sits between the anchor predecessor fetcher and the DP max/backtrack stage.

---
 rtl/chain_score_pipe.sv | 199 +++++++++++++++++++
 tb/tb_chain_score_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_score_pipe.sv
// Four-stage chaining-score pipeline for minimap2 anchor pairs with a
// per-group best-predecessor tracker on the output side.
module chain_score_pipe #(
    parameter int DATA_W    = 32,
    parameter int SCORE_W   = 32,
    parameter int TAG_W     = 16,
    parameter int MAX_DIST  = 5000,
    parameter int BW        = 500,
    parameter int AVG_MUL   = 41,
    parameter int AVG_SHIFT = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [DATA_W-1:0]         riX,
    input  logic [DATA_W-1:0]         riY,
    input  logic [DATA_W-1:0]         qiX,
    input  logic [DATA_W-1:0]         qiY,
    input  logic [DATA_W-1:0]         W,
    input  logic [DATA_W-1:0]         W_avg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [SCORE_W-1:0] out_score,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_last,
    output logic                      best_valid,
    output logic signed [SCORE_W-1:0] best_score,
    output logic [TAG_W-1:0]          best_tag,
    output logic                      best_found
);
    localparam int PROD_W = 2*DATA_W + 8;
    localparam int LOG_W  = $clog2(DATA_W + 1);
    localparam logic signed [DATA_W:0] MAX_D  = (DATA_W+1)'(MAX_DIST);
    localparam logic [DATA_W+1:0]      BW_U   = (DATA_W+2)'(BW);
    localparam logic signed [SCORE_W-1:0] NEG_INF = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic signed [PROD_W+1:0] SAT_HI =
        {{(PROD_W+3-SCORE_W){1'b0}}, {(SCORE_W-1){1'b1}}};
    localparam logic signed [PROD_W+1:0] SAT_LO =
        {{(PROD_W+2-SCORE_W){1'b1}}, 1'b1, {(SCORE_W-2){1'b0}}, 1'b1};

    function automatic logic [LOG_W-1:0] msb_pos(input logic [DATA_W:0] v);
        msb_pos = '0;
        for (int k = 0; k <= DATA_W; k++)
            if (v[k]) msb_pos = LOG_W'(k);
    endfunction

    logic advance;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // S1: signed deltas and range checks
    logic signed [DATA_W:0] dr_c, dq_c;
    logic                   range_ok_c;
    assign dr_c = $signed({1'b0, riX}) - $signed({1'b0, qiX});
    assign dq_c = $signed({1'b0, riY}) - $signed({1'b0, qiY});
    assign range_ok_c = !dr_c[DATA_W] && (dr_c != '0) && (dr_c <= MAX_D) &&
                        !dq_c[DATA_W] && (dq_c != '0) && (dq_c <= MAX_D);

    logic                   s1_valid, s1_last, s1_ok;
    logic [TAG_W-1:0]       s1_tag;
    logic signed [DATA_W:0] s1_dr, s1_dq;
    logic [DATA_W-1:0]      s1_w, s1_w_avg;

    // S2: band distance, alpha and leading-one position
    logic signed [DATA_W+1:0] diff_c;
    logic [DATA_W+1:0]        dd_c;
    logic [DATA_W-1:0]        min_rq_c, alpha_c;
    assign diff_c   = {s1_dr[DATA_W], s1_dr} - {s1_dq[DATA_W], s1_dq};
    assign dd_c     = diff_c[DATA_W+1] ? $unsigned(-diff_c) : $unsigned(diff_c);
    assign min_rq_c = (s1_dr < s1_dq) ? s1_dr[DATA_W-1:0] : s1_dq[DATA_W-1:0];
    assign alpha_c  = (s1_w < min_rq_c) ? s1_w : min_rq_c;

    logic              s2_valid, s2_last, s2_ok;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W:0]   s2_dd;
    logic [DATA_W-1:0] s2_alpha, s2_w_avg;
    logic [LOG_W-1:0]  s2_log;

    logic              s3_valid, s3_last, s3_ok;
    logic [TAG_W-1:0]  s3_tag;
    logic [PROD_W-1:0] s3_prod;
    logic [DATA_W-1:0] s3_alpha;
    logic [LOG_W-1:0]  s3_log;

    // S4: shift, subtract at full width, then clamp into the score range
    logic [PROD_W-1:0]         avg_c;
    logic [PROD_W+1:0]         alpha_x, avg_x, log_x;
    logic signed [PROD_W+1:0]  gap_c;
    logic signed [SCORE_W-1:0] score_c;
    assign avg_c   = s3_prod >> AVG_SHIFT;
    assign alpha_x = (PROD_W+2)'(s3_alpha);
    assign avg_x   = (PROD_W+2)'(avg_c);
    assign log_x   = (PROD_W+2)'(s3_log);
    assign gap_c   = $signed(alpha_x) - $signed(avg_x) - $signed(log_x);

    always_comb begin
        score_c = gap_c[SCORE_W-1:0];
        if (!s3_ok)               score_c = NEG_INF;
        else if (gap_c > SAT_HI)  score_c = SAT_HI[SCORE_W-1:0];
        else if (gap_c < SAT_LO)  score_c = SAT_LO[SCORE_W-1:0];
    end

    // NOTE: the stage datapath carries no reset; the valid bits alone decide
    // whether a stage holds a pair, which keeps reset fan-out to the control.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_last  <= in_last;   s1_tag   <= in_tag;
            s1_dr    <= dr_c;      s1_dq    <= dq_c;
            s1_w     <= W;         s1_w_avg <= W_avg;
            s1_ok    <= range_ok_c;
            s2_last  <= s1_last;   s2_tag   <= s1_tag;
            s2_dd    <= dd_c[DATA_W:0];
            s2_ok    <= s1_ok && (dd_c <= BW_U);
            s2_alpha <= alpha_c;   s2_w_avg <= s1_w_avg;
            s2_log   <= msb_pos(dd_c[DATA_W:0]);
            s3_last  <= s2_last;   s3_tag   <= s2_tag;
            s3_ok    <= s2_ok;     s3_alpha <= s2_alpha;
            s3_log   <= s2_log >> 1;
            s3_prod  <= PROD_W'(s2_dd) * PROD_W'(s2_w_avg) * PROD_W'(AVG_MUL);
        end
    end

    logic out_legal;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_score <= '0;
            out_tag   <= '0;
            out_last  <= 1'b0;
            out_legal <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_score <= score_c;
                out_tag   <= s3_tag;
                out_last  <= s3_last;
                out_legal <= s3_ok;
            end
        end
    end

    // Group tracker: the first tag of a group is kept until a legal pair wins
    logic signed [SCORE_W-1:0] run_score, cand_score;
    logic [TAG_W-1:0]          run_tag, cand_tag;
    logic                      run_found, run_empty, cand_found, out_fire;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        cand_score = run_score;
        cand_tag   = run_empty ? out_tag : run_tag;
        cand_found = run_found;
        if (out_legal && (!run_found || out_score > run_score)) begin
            cand_score = out_score;
            cand_tag   = out_tag;
            cand_found = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_score  <= NEG_INF;
            run_tag    <= '0;
            run_found  <= 1'b0;
            run_empty  <= 1'b1;
            best_valid <= 1'b0;
            best_score <= '0;
            best_tag   <= '0;
            best_found <= 1'b0;
        end else begin
            best_valid <= 1'b0;
            if (out_fire) begin
                if (out_last) begin
                    best_valid <= 1'b1;
                    best_score <= cand_score;
                    best_tag   <= cand_tag;
                    best_found <= cand_found;
                    run_score  <= NEG_INF;
                    run_tag    <= '0;
                    run_found  <= 1'b0;
                    run_empty  <= 1'b1;
                end else begin
                    run_score  <= cand_score;
                    run_tag    <= cand_tag;
                    run_found  <= cand_found;
                    run_empty  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_chain_score_pipe.sv
// Randomised bench for chain_score_pipe: an arithmetic reference model feeds an
// in-order scoreboard that also re-derives each group's best predecessor.
module tb_chain_score_pipe;
    localparam int     DATA_W = 32, SCORE_W = 32, TAG_W = 16;
    localparam longint MAX_DIST = 5000, BW = 500;
    localparam longint NEG_INF = -64'sd2147483648;
    localparam longint SAT_HI  = 64'sd2147483647;

    typedef struct packed {
        logic [31:0] rix, riy, qix, qiy, w, wavg;
        logic [15:0] tag;
        logic        last;
    } pair_t;

    typedef struct {
        longint      score;
        bit          legal;
        logic [15:0] tag;
        bit          last;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic best_valid, best_found;
    logic [TAG_W-1:0] in_tag, out_tag, best_tag;
    logic [DATA_W-1:0] riX, riY, qiX, qiY, W, W_avg;
    logic signed [SCORE_W-1:0] out_score, best_score;

    always #5 clk = ~clk;

    chain_score_pipe #(
        .DATA_W(DATA_W), .SCORE_W(SCORE_W), .TAG_W(TAG_W), .MAX_DIST(5000),
        .BW(500), .AVG_MUL(41), .AVG_SHIFT(12)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_tag(in_tag), .riX(riX), .riY(riY), .qiX(qiX),
        .qiY(qiY), .W(W), .W_avg(W_avg), .out_valid(out_valid),
        .out_ready(out_ready), .out_score(out_score), .out_tag(out_tag),
        .out_last(out_last), .best_valid(best_valid), .best_score(best_score),
        .best_tag(best_tag), .best_found(best_found)
    );

    int   n_checks = 0, n_errors = 0, cyc = 0, ready_mode = 0, rphase = 0;
    bit   lat_mode = 1'b0, best_due = 1'b0, head_seen = 1'b0;
    exp_t exp_q[$];
    exp_t grp_q[$];
    longint exp_best_score;
    logic [15:0] exp_best_tag;
    bit     exp_best_found;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: score straight from the arithmetic definition
    function automatic void model(input pair_t p, output longint score, output bit legal);
        longint dr, dq, dd, alpha, avg, lg, t, s;
        dr = longint'(p.rix) - longint'(p.qix);
        dq = longint'(p.riy) - longint'(p.qiy);
        dd = (dr > dq) ? dr - dq : dq - dr;
        legal = dr > 0 && dq > 0 && dr <= MAX_DIST && dq <= MAX_DIST && dd <= BW;
        score = NEG_INF;
        if (legal) begin
            alpha = dr;
            if (dq < alpha) alpha = dq;
            if (longint'(p.w) < alpha) alpha = longint'(p.w);
            avg = (dd * longint'(p.wavg) * 41) / 4096;
            lg = 0;
            t  = dd;
            while (t > 1) begin
                t = t / 2;
                lg++;
            end
            lg = lg / 2;
            s = alpha - (avg + lg);
            if (s > SAT_HI) s = SAT_HI;
            if (s < NEG_INF + 1) s = NEG_INF + 1;
            score = s;
        end
    endfunction

    function automatic pair_t mk(input longint dr, input longint dq, input longint w,
                                 input longint wavg, input int tag, input bit last);
        pair_t p;
        p.qix  = 32'd100000 + 32'($urandom_range(0, 1000));
        p.qiy  = 32'd200000 + 32'($urandom_range(0, 1000));
        p.rix  = 32'(longint'(p.qix) + dr);
        p.riy  = 32'(longint'(p.qiy) + dq);
        p.w    = 32'(w);
        p.wavg = 32'(wavg);
        p.tag  = 16'(tag);
        p.last = last;
        return p;
    endfunction

    function automatic pair_t rand_pair(input int tag, input bit last);
        longint dr, dq, wavg;
        dr = longint'($urandom_range(0, 5120)) - 20;
        dq = dr + longint'($urandom_range(0, 1100)) - 550;
        if ($urandom_range(0, 7) == 0) dq = dr;
        wavg = ($urandom_range(0, 9) == 0) ? longint'($urandom) : longint'($urandom_range(0, 120));
        return mk(dr, dq, longint'($urandom_range(1, 6000)), wavg, tag, last);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the transfer edge
    task automatic send(input pair_t p);
        int     n = 0;
        bit     ok = 1'b0;
        longint sc;
        bit     lg;
        riX = p.rix; riY = p.riy; qiX = p.qix; qiY = p.qiy;
        W = p.w; W_avg = p.wavg; in_tag = p.tag; in_last = p.last;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                model(p, sc, lg);
                exp_q.push_back('{score: sc, legal: lg, tag: p.tag, last: p.last,
                                  acc_cyc: cyc, chk_lat: lat_mode});
                ok = 1'b1;
            end else begin
                n++;
            end
        end
        check("accept", ok, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || best_due) && n < 500) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        tick();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (rphase == 0);
                    rphase = (rphase + 1) % 3;
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard: in-order results, stall holding, handshake and group best
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            grp_q.delete();
            best_due  = 1'b0;
            head_seen = 1'b0;
        end else begin
            check("best_valid", best_valid, best_due);
            if (best_due) begin
                check("best_score", best_score, exp_best_score);
                check("best_tag", best_tag, exp_best_tag);
                check("best_found", best_found, exp_best_found);
                best_due = 1'b0;
            end
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    if (!head_seen && e.chk_lat) check("latency", cyc - e.acc_cyc, 4);
                    head_seen = 1'b1;
                    check("out_score", out_score, e.score);
                    check("out_tag", out_tag, e.tag);
                    check("out_last", out_last, e.last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        head_seen = 1'b0;
                        grp_q.push_back(e);
                        if (e.last) begin
                            exp_best_found = 1'b0;
                            exp_best_score = NEG_INF;
                            exp_best_tag   = grp_q[0].tag;
                            foreach (grp_q[i])
                                if (grp_q[i].legal &&
                                    (!exp_best_found || grp_q[i].score > exp_best_score)) begin
                                    exp_best_found = 1'b1;
                                    exp_best_score = grp_q[i].score;
                                    exp_best_tag   = grp_q[i].tag;
                                end
                            grp_q.delete();
                            best_due = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_tag = '0;
        riX = '0; riY = '0; qiX = '0; qiY = '0; W = '0; W_avg = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_best_valid", best_valid, 0);
        check("rst_best_found", best_found, 0);
        check("rst_in_ready", in_ready, 1);
        tick();

        // Directed groups, no back-pressure, fixed latency checked
        ready_mode = 0;
        lat_mode   = 1'b1;
        send(mk(50, 10, 40, 40, 7, 1'b1));
        send(mk(20, 20, 40, 40, 1, 1'b0));
        send(mk(15, 12, 40, 40, 2, 1'b0));
        send(mk(20, 20, 40, 40, 3, 1'b1));
        send(mk(10, 0, 40, 40, 11, 1'b0));
        send(mk(-5, 10, 40, 40, 12, 1'b0));
        send(mk(5001, 5001, 6000, 40, 13, 1'b0));
        send(mk(1000, 499, 6000, 40, 14, 1'b1));
        send(mk(100, 100, 8, 40, 21, 1'b0));
        send(mk(500, 1, 100, 64'hFFFF_FFFF, 22, 1'b1));
        drain();

        // Back-to-back stream with output stalls (1,0,0,...)
        lat_mode   = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 10; i++) send(rand_pair(100 + i, i == 9));
        drain();

        // Reset with three pairs in flight
        ready_mode = 0;
        tick();
        for (int i = 0; i < 3; i++) send(mk(30, 30, 50, 10, 200 + i, 1'b0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_score", out_score, 0);
        check("mid_rst_out_tag", out_tag, 0);
        check("mid_rst_best_score", best_score, 0);
        check("mid_rst_best_tag", best_tag, 0);
        check("mid_rst_best_found", best_found, 0);
        check("mid_rst_in_ready", in_ready, 1);
        tick();
        lat_mode = 1'b1;
        send(mk(40, 35, 60, 20, 300, 1'b1));
        drain();

        // Random traffic with random back-pressure and group boundaries
        lat_mode   = 1'b0;
        ready_mode = 2;
        for (int i = 0; i < 300; i++)
            send(rand_pair(1000 + i, (i == 299) || ($urandom_range(0, 3) == 0)));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
